// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: Mini SRC opcodes, ALU codes, sequencer states and control bundles.
package control_sequencer_pkg;
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;
    localparam logic [4:0] ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_AND = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;

    typedef enum logic [3:0] {
        S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
    } state_t;

    typedef struct packed {
        logic rtype, itype, ld, ldi, st, muldiv, unary, br, nop, halt, ill;
    } class_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, ba_out, c_out;
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
        logic y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, con_in;
        logic read, write;
    } ctl_t;
endpackage

// File: rtl/control_sequencer_class_decode.sv
// opcode_class_decode: maps a 5-bit opcode to a one-hot instruction class.
module opcode_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [4:0] i_opcode,
    output class_t     o_class
);
    always_comb begin
        o_class        = '0;
        o_class.rtype  = i_opcode inside {[OP_ADD:OP_SHL]};
        o_class.itype  = i_opcode inside {[OP_ADDI:OP_ORI]};
        o_class.ld     = i_opcode == OP_LD;
        o_class.ldi    = i_opcode == OP_LDI;
        o_class.st     = i_opcode == OP_ST;
        o_class.muldiv = i_opcode inside {OP_DIV, OP_MUL};
        o_class.unary  = i_opcode inside {OP_NEG, OP_NOT};
        o_class.br     = i_opcode == OP_BR;
        o_class.nop    = i_opcode == OP_NOP;
        o_class.halt   = i_opcode == OP_HALT;
        o_class.ill    = !(i_opcode inside {[OP_LD:OP_BR], OP_NOP, OP_HALT});
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM driving the Mini SRC datapath through fetch and per-opcode micro-steps.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPW             = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           stop,
    input  logic [31:0]    ir,
    input  logic           con,
    output logic           run,
    output logic           gra, grb, grc, rin, rout, ba_out, c_out,
    output logic           pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
    output logic           y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, con_in,
    output logic           read, write,
    output logic [OPW-1:0] alu_op
);
    state_t     r_state, w_next;
    class_t     w_cls;
    ctl_t       w_ctl;
    logic [4:0] w_opc, w_alu, w_iop;
    logic       w_last, w_unused;

    assign w_opc    = ir[31:27];
    assign w_unused = ^ir[26:0];

    opcode_class_decode u_dec (.i_opcode(w_opc), .o_class(w_cls));

    // T7 and non-sequencing classes always terminate, so a corrupted ir can never wedge the FSM.
    assign w_last = (r_state == T4 && w_cls.unary)
                 || (r_state == T5 && (w_cls.rtype || w_cls.itype || w_cls.ldi))
                 || (r_state == T6 && (w_cls.muldiv || w_cls.br))
                 || r_state == T7 || w_cls.nop || w_cls.halt || w_cls.ill;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = T0;
            T0:      w_next = stop ? S_HALT : T1;
            T1:      w_next = T2;
            T2:      w_next = (w_cls.halt || (w_cls.ill && HALT_ON_ILLEGAL)) ? S_HALT :
                              (w_cls.nop || w_cls.ill) ? T0 : T3;
            S_HALT:  w_next = S_HALT;
            default: w_next = w_last ? T0 : state_t'(r_state + 4'd1);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_RESET;
        else          r_state <= w_next;
    end

    assign w_iop = w_opc == OP_ANDI ? ALU_AND : w_opc == OP_ORI ? ALU_OR : ALU_ADD;

    always_comb begin
        w_ctl = '0;
        w_alu = '0;
        case (r_state)
            T0: begin
                {w_ctl.pc_out, w_ctl.mar_in, w_ctl.inc_pc, w_ctl.z_in} = '1;
                w_alu = ALU_ADD;
            end
            T1: {w_ctl.zlo_out, w_ctl.pc_in, w_ctl.read, w_ctl.mdr_in} = '1;
            T2: {w_ctl.mdr_out, w_ctl.ir_in} = '1;
            T3: begin
                w_ctl.grb    = w_cls.rtype || w_cls.itype || w_cls.ld || w_cls.ldi || w_cls.st || w_cls.unary;
                w_ctl.gra    = w_cls.muldiv || w_cls.br;
                w_ctl.rout   = w_cls.rtype || w_cls.itype || w_cls.muldiv || w_cls.unary || w_cls.br;
                w_ctl.ba_out = w_cls.ld || w_cls.ldi || w_cls.st;
                w_ctl.y_in   = w_cls.rtype || w_cls.itype || w_cls.ld || w_cls.ldi || w_cls.st || w_cls.muldiv;
                w_ctl.z_in   = w_cls.unary;
                w_ctl.con_in = w_cls.br;
                w_alu        = w_cls.unary ? w_opc : 5'd0;
            end
            T4: begin
                w_ctl.grc     = w_cls.rtype;
                w_ctl.grb     = w_cls.muldiv;
                w_ctl.rout    = w_cls.rtype || w_cls.muldiv;
                w_ctl.c_out   = w_cls.itype || w_cls.ld || w_cls.ldi || w_cls.st;
                w_ctl.z_in    = w_cls.rtype || w_cls.muldiv || w_ctl.c_out;
                w_ctl.zlo_out = w_cls.unary;
                w_ctl.gra     = w_cls.unary;
                w_ctl.rin     = w_cls.unary;
                w_ctl.pc_out  = w_cls.br;
                w_ctl.y_in    = w_cls.br;
                w_alu         = (w_cls.rtype || w_cls.muldiv) ? w_opc : w_cls.itype ? w_iop :
                                (w_cls.ld || w_cls.ldi || w_cls.st) ? ALU_ADD : 5'd0;
            end
            T5: begin
                w_ctl.zlo_out = !w_cls.br;
                w_ctl.gra     = w_cls.rtype || w_cls.itype || w_cls.ldi;
                w_ctl.rin     = w_ctl.gra;
                w_ctl.mar_in  = w_cls.ld || w_cls.st;
                w_ctl.lo_in   = w_cls.muldiv;
                w_ctl.c_out   = w_cls.br;
                w_ctl.z_in    = w_cls.br;
                w_alu         = w_cls.br ? ALU_ADD : 5'd0;
            end
            T6: begin
                w_ctl.read    = w_cls.ld;
                w_ctl.mdr_in  = w_cls.ld || w_cls.st;
                w_ctl.gra     = w_cls.st;
                w_ctl.rout    = w_cls.st;
                w_ctl.zhi_out = w_cls.muldiv;
                w_ctl.hi_in   = w_cls.muldiv;
                w_ctl.zlo_out = w_cls.br && con;
                w_ctl.pc_in   = w_cls.br && con;
            end
            T7: begin
                w_ctl.mdr_out = w_cls.ld;
                w_ctl.gra     = w_cls.ld;
                w_ctl.rin     = w_cls.ld;
                w_ctl.write   = w_cls.st;
            end
            default: ;
        endcase
    end

    assign run = r_state != S_RESET && r_state != S_HALT;
    assign {gra, grb, grc, rin, rout, ba_out, c_out,
            pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
            y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, con_in,
            read, write} = w_ctl;
    assign alu_op = OPW'(w_alu);
endmodule
